// File: rtl/plant_property_writer.sv
// plant_property_writer
// ---------------------
// Writes one 9-word plant property entry into the EMIB device property table.
// A request (i_plant_write_irq with i_config_flag high, sampled only while idle)
// captures the plant record. The entry index is the low byte of the MAC. Valid
// indices 0x01..0xFE are written as nine 16-bit words starting at
// base + (index-1)*9. Indices 0x00 and 0xFF are rejected with an error pulse.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_plant_write_irq             write request (level, sampled in IDLE)
//   i_config_flag                 request qualifier
//   i_plant_mac/ip/toffset/
//   i_plant_datalen/interval      plant record fields
//   i_emib_device_property_addr   property table base address
//   i_ram_wr_grant                RAM accepts the presented word this cycle
//   o_emib_addr, o_wr_data        RAM write address / data
//   o_wr_ram_en                   RAM write request
//   o_plant_write_busy            high whenever not idle
//   o_plant_write_done            one-cycle pulse after the last word
//   o_plant_write_error           one-cycle pulse on a rejected index
module plant_property_writer #(
   parameter int ADDR_SZ = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_plant_write_irq,
   input  logic               i_config_flag,
   input  logic [47:0]        i_plant_mac,
   input  logic [31:0]        i_plant_ip,
   input  logic [31:0]        i_plant_toffset,
   input  logic [15:0]        i_plant_datalen,
   input  logic [15:0]        i_plant_interval,
   input  logic [ADDR_SZ-1:0] i_emib_device_property_addr,
   input  logic               i_ram_wr_grant,
   output logic [ADDR_SZ-1:0] o_emib_addr,
   output logic [15:0]        o_wr_data,
   output logic               o_wr_ram_en,
   output logic               o_plant_write_busy,
   output logic               o_plant_write_done,
   output logic               o_plant_write_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_WR_WORD,
      S_DONE,
      S_ERROR
   } state_t;

   state_t             r_state, w_state_next;
   logic [3:0]         r_word, w_word_next;

   // Captured plant record; the entry is built only from these copies.
   logic [47:0]        r_mac;
   logic [31:0]        r_ip;
   logic [31:0]        r_toffset;
   logic [14:0]        r_datalen;
   logic [15:0]        r_interval;
   logic [ADDR_SZ-1:0] r_base;

   logic [ADDR_SZ-1:0] r_addr, w_addr_next;
   logic [15:0]        r_wr_data, w_wr_data_next;
   logic               r_wr_en, w_wr_en_next;
   logic               r_busy, w_busy_next;
   logic               r_done, w_done_next;
   logic               r_error, w_error_next;

   logic               w_accept;
   logic               w_bad_index;
   logic               w_word_accept;
   logic [11:0]        w_entry_offset;
   logic [ADDR_SZ-1:0] w_entry_addr;
   logic [15:0]        w_word_data;
   logic               w_unused_ok;

   // The top bit of datalen is lost when the length is stored doubled.
   assign w_unused_ok    = i_plant_datalen[15];

   assign w_accept       = i_plant_write_irq & i_config_flag;
   assign w_bad_index    = (r_mac[7:0] == 8'h00) || (r_mac[7:0] == 8'hFF);
   assign w_word_accept  = (r_state == S_WR_WORD) && i_ram_wr_grant;
   // (index-1)*9 peaks at 253*9 = 2277, which fits 12 bits.
   assign w_entry_offset = ({4'b0000, r_mac[7:0]} - 12'd1) * 12'd9;
   assign w_entry_addr   = r_base + ADDR_SZ'(w_entry_offset);

   // State register and all registered outputs share one edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_word     <= '0;
         r_addr     <= '0;
         r_wr_data  <= '0;
         r_wr_en    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_mac      <= '0;
         r_ip       <= '0;
         r_toffset  <= '0;
         r_datalen  <= '0;
         r_interval <= '0;
         r_base     <= '0;
      end else begin
         r_state   <= w_state_next;
         r_word    <= w_word_next;
         r_addr    <= w_addr_next;
         r_wr_data <= w_wr_data_next;
         r_wr_en   <= w_wr_en_next;
         r_busy    <= w_busy_next;
         r_done    <= w_done_next;
         r_error   <= w_error_next;
         if ((r_state == S_IDLE) && w_accept) begin
            r_mac      <= i_plant_mac;
            r_ip       <= i_plant_ip;
            r_toffset  <= i_plant_toffset;
            r_datalen  <= i_plant_datalen[14:0];
            r_interval <= i_plant_interval;
            r_base     <= i_emib_device_property_addr;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      w_word_next  = r_word;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = S_CHECK;
            end
         end
         S_CHECK: begin
            w_word_next  = 4'd0;
            w_state_next = w_bad_index ? S_ERROR : S_WR_WORD;
         end
         S_WR_WORD: begin
            if (w_word_accept) begin
               if (r_word == 4'd8) begin
                  w_state_next = S_DONE;
               end else begin
                  w_word_next = r_word + 4'd1;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Word selection for the word that will be presented next cycle.
   always_comb begin
      w_word_data = 16'h0000;
      case (w_word_next)
         4'd0:    w_word_data = r_ip[31:16];
         4'd1:    w_word_data = r_ip[15:0];
         4'd2:    w_word_data = r_mac[47:32];
         4'd3:    w_word_data = r_mac[31:16];
         4'd4:    w_word_data = r_mac[15:0];
         4'd5:    w_word_data = r_toffset[31:16];
         4'd6:    w_word_data = r_toffset[15:0];
         4'd7:    w_word_data = {r_datalen, 1'b0};
         4'd8:    w_word_data = r_interval;
         default: w_word_data = 16'h0000;
      endcase
   end

   // Output logic: next values of the registered outputs.
   always_comb begin
      w_wr_en_next   = (w_state_next == S_WR_WORD);
      w_wr_data_next = w_wr_en_next ? w_word_data : 16'h0000;
      w_busy_next    = (w_state_next != S_IDLE);
      w_done_next    = (w_state_next == S_DONE);
      w_error_next   = (w_state_next == S_ERROR);
      case (r_state)
         S_CHECK:   w_addr_next = w_entry_addr;
         S_WR_WORD: w_addr_next = w_word_accept ? (r_addr + ADDR_SZ'(1)) : r_addr;
         default:   w_addr_next = r_addr;
      endcase
   end

   // Outside a word write the address port mirrors the live table base.
   assign o_emib_addr         = (r_state == S_WR_WORD) ? r_addr : i_emib_device_property_addr;
   assign o_wr_data           = r_wr_data;
   assign o_wr_ram_en         = r_wr_en;
   assign o_plant_write_busy  = r_busy;
   assign o_plant_write_done  = r_done;
   assign o_plant_write_error = r_error;

endmodule

// File: doc/plant_property_writer.md
PLANT_PROPERTY_WRITER -- requirements
Module: plant_property_writer

Interface
REQ-001 SHALL have parameter ADDR_SZ, default 16: width of the EMIB RAM word address.
REQ-002 SHALL have port i_clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_plant_write_irq  in  1  write request; level sampled in IDLE.
REQ-005 SHALL have port i_config_flag  in  1  request is accepted only while high.
REQ-006 SHALL have port i_plant_mac  in  48  plant MAC; [7:0] is the table index.
REQ-007 SHALL have port i_plant_ip  in  32  plant IP address.
REQ-008 SHALL have port i_plant_toffset  in  32  plant time offset.
REQ-009 SHALL have port i_plant_datalen  in  16  send data length in words.
REQ-010 SHALL have port i_plant_interval  in  16  plant send interval.
REQ-011 SHALL have port i_emib_device_property_addr  in  ADDR_SZ  device property table base address.
REQ-012 SHALL have port i_ram_wr_grant  in  1  RAM accepts the presented write this cycle.
REQ-013 SHALL have port o_emib_addr  out  ADDR_SZ  RAM write address.
REQ-014 SHALL have port o_wr_data  out  16  RAM write data.
REQ-015 SHALL have port o_wr_ram_en  out  1  write request to RAM.
REQ-016 SHALL have port o_plant_write_busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port o_plant_write_done  out  1  one-cycle pulse on success.
REQ-018 SHALL have port o_plant_write_error  out  1  one-cycle pulse on rejected index.

Function
REQ-019 SHALL provide states IDLE, CHECK, WR_WORD (word counter 0..8), DONE and ERROR; all outputs are registers updated on the same edge as the state.
REQ-020 SHALL leave IDLE for CHECK when i_plant_write_irq=1 and i_config_flag=1, capturing MAC, IP, toffset, datalen, interval and base address on that edge; later input changes SHALL NOT affect the entry.
REQ-021 SHALL ignore i_plant_write_irq in every state except IDLE; there is no queuing.
REQ-022 In CHECK, index 0x01..0xFE SHALL go to WR_WORD with word 0; index 0x00 or 0xFF SHALL go to ERROR with no RAM write.
REQ-023 SHALL compute the entry address as base + (index-1)*9, truncated to ADDR_SZ bits, then increment it by 1 per word.
REQ-024 SHALL write word k at entry+k: 0 IP[31:16], 1 IP[15:0], 2 MAC[47:32], 3 MAC[31:16], 4 MAC[15:0], 5 toffset[31:16], 6 toffset[15:0], 7 {datalen[14:0],1'b0} (stored doubled, datalen[15] discarded), 8 interval.
REQ-025 In WR_WORD, o_wr_ram_en SHALL be 1 with o_emib_addr/o_wr_data stable; a word is accepted on an edge where o_wr_ram_en=1 and i_ram_wr_grant=1.
REQ-026 While i_ram_wr_grant=0, address, data, enable and the word counter SHALL hold, with no timeout.
REQ-027 On acceptance of word 8 the block SHALL go to DONE with o_wr_ram_en=0; DONE and ERROR each SHALL last one cycle, then return to IDLE.
REQ-028 o_plant_write_done SHALL be 1 only in DONE; o_plant_write_error SHALL be 1 only in ERROR; the two SHALL never be high together.
REQ-029 With grant held high, the first write SHALL be presented 2 cycles after the request edge and done SHALL be high in the 11th cycle after it.
REQ-030 Outside WR_WORD, o_wr_ram_en SHALL be 0, o_wr_data 16'h0000 and o_emib_addr the live i_emib_device_property_addr.

Reset
REQ-031 On any edge with i_rst=1, including mid-write, the block SHALL enter IDLE with o_wr_ram_en, busy, done, error and o_wr_data all 0, and o_emib_addr equal to i_emib_device_property_addr.
REQ-032 A partially written entry SHALL be left as is after reset; no rollback.
REQ-033 Reset SHALL take priority over a simultaneous request.

Verification
REQ-034 Base 0x0100, MAC[7:0]=0x03, IP 0xC0A80A05, toffset 0x00012345, datalen 0x0020, interval 0x03E8, grant=1 -> writes at 0x0112..0x011A: C0A8, 0A05, MAC words, 0001, 2345, 0040, 03E8; done on the 11th cycle.
REQ-035 MAC[7:0]=0x00, then 0xFF -> no o_wr_ram_en; error pulses 2 cycles after each request; done stays 0.
REQ-036 Grant low for 3 cycles at word 5 -> address 0x0117 and data 0x0001 held for 4 cycles; sequence then resumes; done is delayed by 3 cycles.
REQ-037 i_config_flag=0 with irq=1 -> stays IDLE with busy=0; a second irq during busy -> ignored, exactly 9 writes.
REQ-038 i_rst=1 while word 4 is presented -> next cycle en=0, busy=0; a new request afterwards starts again from word 0.
REQ-039 Base 0xFFF0, index 0x02 -> word addresses 0xFFF9..0xFFFF, then wrap to 0x0000 and 0x0001.
